// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Single-port data memory for the processor datapath. Stores the low DATA_W
//   bits of each bus write and returns registered read data. A req/ready
//   handshake gates access. After reset an optional sweep zeroes every word.
//   A rectangular window of words is mirrored onto flat tap outputs by
//   write-through shadow registers, so the RAM itself needs only one port.
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset
//   req       in   transaction request, accepted when req && ready
//   write_en  in   1 = write, 0 = read (sampled with req)
//   addr      in   word address (ADDR_W)
//   datain    in   write data (BUS_W), low DATA_W bits stored
//   ready     out  block can accept a transaction this cycle (~busy)
//   dataout   out  registered read data (DATA_W)
//   rvalid    out  one-cycle pulse, dataout holds new read data
//   addr_err  out  one-cycle pulse, accepted access had addr >= DEPTH
//   busy      out  clear sweep in progress
//   taps      out  tap words, word k = r*TAP_COLS+c at [k*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int DATA_W         = 12,
  parameter int BUS_W          = 17,
  parameter int ADDR_W         = 12,
  parameter int DEPTH          = 4096,
  parameter int TAP_BASE       = 2,
  parameter int TAP_ROWS       = 2,
  parameter int TAP_COLS       = 2,
  parameter int TAP_STRIDE     = 64,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req,
  input  logic                                 write_en,
  input  logic [ADDR_W-1:0]                    addr,
  input  logic [BUS_W-1:0]                     datain,
  output logic                                 ready,
  output logic [DATA_W-1:0]                    dataout,
  output logic                                 rvalid,
  output logic                                 addr_err,
  output logic                                 busy,
  output logic [TAP_ROWS*TAP_COLS*DATA_W-1:0]  taps
);

  localparam int NTAP = TAP_ROWS * TAP_COLS;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  // One extra bit so DEPTH = 2^ADDR_W is representable in the range compare.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [0:0]        RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] dataout_q;
  logic              rvalid_q, addr_err_q;
  logic [DATA_W-1:0] tap_q [NTAP];
  logic [DATA_W-1:0] ram_mem [DEPTH];

  logic              accept, in_range, wr_ok, rd_ok;
  logic [DATA_W-1:0] wdata;

  assign busy     = (state_q == ST_CLEAR);
  assign ready    = ~busy;
  assign accept   = req & ready;
  assign in_range = ({1'b0, addr} < DEPTH_X);
  assign wr_ok    = accept & write_en & in_range;
  assign rd_ok    = accept & ~write_en;
  assign wdata    = datain[DATA_W-1:0];

  generate
    if (BUS_W > DATA_W) begin : g_bus_hi
      // Upper bus bits are intentionally discarded.
      logic unused_bus_hi;
      assign unused_bus_hi = ^datain[BUS_W-1:DATA_W];
    end
  endgenerate

  // Clear sweep: one word per cycle, leave on the edge writing DEPTH-1.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_ADDR) begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // RAM array without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (busy) begin
      ram_mem[clr_cnt_q] <= '0;
    end else if (wr_ok) begin
      ram_mem[addr] <= wdata;
    end
  end

  // Registered read port; out-of-range reads return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataout_q  <= '0;
      rvalid_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rvalid_q   <= rd_ok;
      addr_err_q <= accept & ~in_range;
      if (rd_ok) begin
        dataout_q <= in_range ? ram_mem[addr] : '0;
      end
    end
  end

  assign dataout  = dataout_q;
  assign rvalid   = rvalid_q;
  assign addr_err = addr_err_q;

  // Write-through tap shadows; held at zero while the sweep runs so they
  // stay consistent with the RAM being zeroed.
  generate
    for (genvar gi = 0; gi < NTAP; gi++) begin : g_tap
      localparam int TAP_ADDR = TAP_BASE + (gi / TAP_COLS) * TAP_STRIDE + (gi % TAP_COLS);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tap_q[gi] <= '0;
        end else if (busy) begin
          tap_q[gi] <= '0;
        end else if (wr_ok && (addr == ADDR_W'(TAP_ADDR))) begin
          tap_q[gi] <= wdata;
        end
      end

      assign taps[gi*DATA_W +: DATA_W] = tap_q[gi];
    end
  endgenerate

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised single-port data memory for the processor datapath. Accepts bus-width write data, stores the low `DATA_W` bits, and returns registered read data. Uses a `req`/`ready` handshake and clears all memory after reset. Mirrors a configurable rectangular window of words (`TAP_ROWS` × `TAP_COLS`, row stride `TAP_STRIDE`) onto flat tap outputs for the display and debug logic.

## Interface
- `DATA_W`, 12, stored word width
- `BUS_W`, 17, width of incoming bus data; must be ≥ `DATA_W`
- `ADDR_W`, 12, address width
- `DEPTH`, 4096, number of words; must be ≤ 2^`ADDR_W`
- `TAP_BASE`, 2, address of tap word (0,0)
- `TAP_ROWS`, 2, tap window rows
- `TAP_COLS`, 2, tap window columns
- `TAP_STRIDE`, 64, address distance between tap rows
- `CLEAR_ON_RESET`, 1, 1 = zero all `DEPTH` words after reset; 0 = skip clear
- `clk`  in  1  clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  1  transaction request
- `write_en`  in  1  1 = write, 0 = read; sampled with `req`
- `addr`  in  `ADDR_W`  word address
- `datain`  in  `BUS_W`  write data; bits [`DATA_W`-1:0] stored
- `ready`  out  1  block can accept a transaction this cycle
- `dataout`  out  `DATA_W`  read data
- `rvalid`  out  1  one-cycle pulse: `dataout` holds new read data
- `addr_err`  out  1  one-cycle pulse: accepted access had `addr` ≥ `DEPTH`
- `busy`  out  1  clear sweep in progress
- `taps`  out  `TAP_ROWS`*`TAP_COLS`*`DATA_W`  tap words; word k = r*`TAP_COLS`+c occupies bits [k*`DATA_W` +: `DATA_W`]

## Operation
- States: CLEAR, IDLE.
  - Reset enters CLEAR if `CLEAR_ON_RESET`=1, otherwise IDLE.
  - CLEAR writes 0 to addresses 0…`DEPTH`-1, one per cycle, via an internal counter, then moves to IDLE.
- `ready` is `~busy` (combinational from state). A transaction is accepted when `req && ready`. `req` while busy is ignored, not queued.
- Accepted write with `addr` < `DEPTH`:
  - `ram[addr]` ← `datain[DATA_W-1:0]`.
  - If `addr` is a tap address, the matching tap register takes the same value.
  - `rvalid` stays 0 and `dataout` is unchanged.
- Accepted read with `addr` < `DEPTH`: `dataout` ← `ram[addr]` and `rvalid` pulses.
- Accepted access with `addr` ≥ `DEPTH`:
  - A write is dropped.
  - A read returns `dataout` = 0 with `rvalid` pulsing.
  - `addr_err` pulses in both cases.
- Tap address (r,c) = `TAP_BASE` + r*`TAP_STRIDE` + c. Tap registers are write-through shadows, so the RAM needs only one port.
- During CLEAR, all tap registers are held at 0.
- With `CLEAR_ON_RESET`=0, taps reset to 0 while RAM contents are undefined. Tap and RAM contents then agree only after the tap address is written.

## Timing
- Reset values: `dataout`=0, `rvalid`=0, `addr_err`=0, `taps`=0. `busy`=`CLEAR_ON_RESET` and `ready`=~`CLEAR_ON_RESET`.
- Clear takes exactly `DEPTH` cycles after `rst_n` rises. `busy` falls and `ready` rises on the edge that completes the write of address `DEPTH`-1.
- Read latency is 1 cycle: a read accepted at edge n gives `dataout`/`rvalid` valid after edge n+1.
- Write-then-read of the same address on consecutive cycles returns the new data.
- Tap update latency is 1 cycle: taps reflect a write after the edge that accepts it.
- `addr_err` is registered and aligned with the edge that accepts the access.
- `rst_n` falling mid-clear or mid-access aborts immediately and asynchronously. On release, the clear restarts from address 0.
- Back-to-back accepted transactions are allowed every cycle in IDLE.

## Test plan
- Reset, `CLEAR_ON_RESET`=1, `DEPTH`=4096 → `busy`=1 for 4096 cycles. Reads of addresses 0, 2, 4095 then return 0 with `rvalid`. `taps`=0.
- Write 0x1ABCD to addr 66 → stored value 0xBCD; tap word 2 = 0xBCD one cycle later. Read 66 → `dataout`=0xBCD, 1-cycle latency.
- Write 21, 22, 23, 24 to addrs 2, 3, 66, 67, back-to-back → `taps` = {24,23,22,21} (word 3…0). A write to addr 4 leaves `taps` unchanged.
- With `DEPTH`=3000: read addr 3500 → `dataout`=0, `rvalid`=1, `addr_err`=1. Write 0x5 to 3500, then read addr 3500-2048 → original contents, not 0x5.
- Assert `req` during clear → `ready`=0, request ignored, no `rvalid`. Drop `rst_n` at clear address 1000 → on release, clear restarts at 0 and `busy` lasts a full 4096 cycles.
- Write 7 to addr 10, then read addr 10 on the next cycle → `dataout`=7. Alternate reads/writes every cycle for 64 cycles → every read matches a reference model.
